// File: rtl/traffic_light_multiphase_if.sv
// Lamp/control bundle between the multiphase signal controller and the intersection top.
// Optional pedestrian signals exist only when PED_WALK_EN is defined.
interface traffic_light_multiphase_if #(
   parameter int N_DIR = 4
);
   localparam int PW = $clog2(N_DIR);

   logic             hold;
   logic [N_DIR-1:0] red;
   logic [N_DIR-1:0] yellow;
   logic [N_DIR-1:0] green;
   logic [PW-1:0]    phase;
`ifdef PED_WALK_EN
   logic             ped_req;
   logic             walk;

   modport master (input hold, input ped_req,
                   output red, output yellow, output green, output phase, output walk);
   modport slave  (output hold, output ped_req,
                   input red, input yellow, input green, input phase, input walk);
`else
   modport master (input hold,
                   output red, output yellow, output green, output phase);
   modport slave  (output hold,
                   input red, input yellow, input green, input phase);
`endif
endinterface

// File: rtl/traffic_light_multiphase.sv
// N-approach signal controller: green/yellow/all-red rotation, lamps decoded combinationally from state+phase.
// Latency: lamps change on the state-change edge; hold freezes state/phase/cnt (no other backpressure).
// PED_WALK_EN adds ped_req, walk and an S_WALK phase after the all-red clearance.
module traffic_light_multiphase #(
   parameter int N_DIR      = 4,
   parameter int CNT_W      = 8,
   parameter int GREEN_CYC  = 8,
   parameter int YELLOW_CYC = 3,
   parameter int ALLRED_CYC = 2,
   parameter int WALK_CYC   = 5
) (
   input logic                        clk,
   input logic                        rst_n,
   traffic_light_multiphase_if.master bus
);
   localparam int PW = $clog2(N_DIR);

`ifdef PED_WALK_EN
   typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_WALK} state_t;
`else
   typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED} state_t;
`endif

   state_t           r_state, w_state_nxt;
   logic [PW-1:0]    r_phase, w_phase_nxt, w_phase_inc;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_dur;
   logic             w_last;
   logic [N_DIR-1:0] w_red, w_yellow, w_green;

   initial begin
      if (N_DIR < 2 || N_DIR > 8)
         $fatal(1, "traffic_light_multiphase: N_DIR=%0d out of range", N_DIR);
      if (GREEN_CYC < 1 || GREEN_CYC >= 2**CNT_W || YELLOW_CYC < 1 || YELLOW_CYC >= 2**CNT_W ||
          ALLRED_CYC < 1 || ALLRED_CYC >= 2**CNT_W || WALK_CYC < 1 || WALK_CYC >= 2**CNT_W)
         $fatal(1, "traffic_light_multiphase: dwell duration out of range");
   end

`ifdef PED_WALK_EN
   logic r_ped_pend, w_ped_pend_nxt, w_enter_walk;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_ALLRED;
         r_phase <= PW'(N_DIR - 1);
         r_cnt   <= '0;
      end else if (!bus.hold) begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

`ifdef PED_WALK_EN
   // Request latches even while held; a pulse coinciding with walk entry re-arms the flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ped_pend <= 1'b0;
      else        r_ped_pend <= w_ped_pend_nxt;
   end
`endif

   always_comb begin
      w_phase_inc = (r_phase == PW'(N_DIR - 1)) ? '0 : r_phase + PW'(1);
      case (r_state)
         S_GREEN:  w_dur = CNT_W'(GREEN_CYC);
         S_YELLOW: w_dur = CNT_W'(YELLOW_CYC);
`ifdef PED_WALK_EN
         S_WALK:   w_dur = CNT_W'(WALK_CYC);
`endif
         default:  w_dur = CNT_W'(ALLRED_CYC);
      endcase
      w_last      = (r_cnt == w_dur - CNT_W'(1));
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
`ifdef PED_WALK_EN
      w_enter_walk = 1'b0;
`endif
      if (w_last) begin
         w_cnt_nxt = '0;
         case (r_state)
            S_GREEN:  w_state_nxt = S_YELLOW;
            S_YELLOW: w_state_nxt = S_ALLRED;
`ifdef PED_WALK_EN
            S_WALK: begin
               w_state_nxt = S_GREEN;
               w_phase_nxt = w_phase_inc;
            end
            default: begin
               if (r_ped_pend) begin
                  w_state_nxt  = S_WALK;
                  w_enter_walk = !bus.hold;
               end else begin
                  w_state_nxt = S_GREEN;
                  w_phase_nxt = w_phase_inc;
               end
            end
`else
            default: begin
               w_state_nxt = S_GREEN;
               w_phase_nxt = w_phase_inc;
            end
`endif
         endcase
      end
`ifdef PED_WALK_EN
      w_ped_pend_nxt = (w_enter_walk ? 1'b0 : r_ped_pend) | bus.ped_req;
`endif
   end

   always_comb begin
      w_red    = '1;
      w_yellow = '0;
      w_green  = '0;
      case (r_state)
         S_GREEN: begin
            w_green[r_phase] = 1'b1;
            w_red[r_phase]   = 1'b0;
         end
         S_YELLOW: begin
            w_yellow[r_phase] = 1'b1;
            w_red[r_phase]    = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus.red    = w_red;
   assign bus.yellow = w_yellow;
   assign bus.green  = w_green;
   assign bus.phase  = r_phase;
`ifdef PED_WALK_EN
   assign bus.walk   = (r_state == S_WALK);
`endif
endmodule

// File: tb/tb_traffic_light_multiphase.sv
// Directed bench for traffic_light_multiphase: N_DIR=3, G=4, Y=2, AR=1, WALK=3.
// Pedestrian steps are included only when PED_WALK_EN is defined.
module tb_traffic_light_multiphase;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   traffic_light_multiphase_if #(.N_DIR(3)) bus ();

   traffic_light_multiphase #(
      .N_DIR(3), .CNT_W(8), .GREEN_CYC(4), .YELLOW_CYC(2), .ALLRED_CYC(1), .WALK_CYC(3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // st: 0 green, 1 yellow, 2 all-red, 3 walk
   task automatic cmp_lamps(input string tag, input int st, input int ph);
      logic [2:0] er, ey, eg;
      int         nonred;
      int         lit;
      er = 3'b111;
      ey = 3'b000;
      eg = 3'b000;
      if (st == 0) begin
         eg[ph] = 1'b1;
         er[ph] = 1'b0;
      end else if (st == 1) begin
         ey[ph] = 1'b1;
         er[ph] = 1'b0;
      end
      check({tag, ".red"},    32'(bus.red),    32'(er));
      check({tag, ".yellow"}, 32'(bus.yellow), 32'(ey));
      check({tag, ".green"},  32'(bus.green),  32'(eg));
      check({tag, ".phase"},  32'(bus.phase),  32'(ph));
`ifdef PED_WALK_EN
      check({tag, ".walk"},   32'(bus.walk),   32'(st == 3));
`endif
      nonred = 0;
      for (int i = 0; i < 3; i++) begin
         lit = int'(bus.red[i]) + int'(bus.yellow[i]) + int'(bus.green[i]);
         check({tag, ".one_lamp"}, 32'(lit), 32'd1);
         if (!bus.red[i]) nonred++;
      end
      check({tag, ".nonred_le1"}, 32'(nonred <= 1), 32'd1);
   endtask

   initial begin
      int st;
      int ph;
      int s;
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      bus.hold    = 1'b0;
`ifdef PED_WALK_EN
      bus.ped_req = 1'b0;
`endif

      // Reset held for two clocks
      repeat (2) @(posedge clk);
      @(negedge clk);
      cmp_lamps("reset", 2, 2);

      // Release; first edge completes the 1-cycle clearance
      rst_n = 1'b1;
      tick();
      cmp_lamps("startup", 0, 0);

      // Rotation: 7 clocks per approach, back to green[0] at clock 21
      for (int k = 1; k <= 21; k++) begin
         tick();
         s  = k % 7;
         ph = (k / 7) % 3;
         st = (s < 4) ? 0 : (s < 6) ? 1 : 2;
         cmp_lamps($sformatf("rot%0d", k), st, ph);
      end

      // Advance to green cnt=2, then hold 5 clocks
      tick();
      tick();
      bus.hold = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         cmp_lamps($sformatf("hold%0d", k), 0, 0);
      end
      bus.hold = 1'b0;
      tick();
      cmp_lamps("hold_rel1", 0, 0);
      tick();
      cmp_lamps("hold_rel2", 1, 0);

      // Asynchronous reset mid-yellow, between edges
      #2 rst_n = 1'b0;
      #1 cmp_lamps("async_rst", 2, 2);
      @(posedge clk);
      @(negedge clk);
      cmp_lamps("rst_held", 2, 2);
      rst_n = 1'b1;
      tick();
      cmp_lamps("restart", 0, 0);

`ifdef PED_WALK_EN
      // Request in green[0]; second request during walk serves the next clearance
      bus.ped_req = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 1) bus.ped_req = 1'b0;
         if (k <= 3)       begin st = 0; ph = 0; end
         else if (k <= 5)  begin st = 1; ph = 0; end
         else if (k == 6)  begin st = 2; ph = 0; end
         else if (k <= 9)  begin st = 3; ph = 0; end
         else if (k <= 13) begin st = 0; ph = 1; end
         else if (k <= 15) begin st = 1; ph = 1; end
         else if (k == 16) begin st = 2; ph = 1; end
         else if (k <= 19) begin st = 3; ph = 1; end
         else              begin st = 0; ph = 2; end
         cmp_lamps($sformatf("ped%0d", k), st, ph);
         if (k == 8) bus.ped_req = 1'b1;
         if (k == 9) bus.ped_req = 1'b0;
      end
`else
      for (int k = 1; k <= 7; k++) begin
         tick();
         s  = k % 7;
         ph = k / 7;
         st = (s < 4) ? 0 : (s < 6) ? 1 : 2;
         cmp_lamps($sformatf("post%0d", k), st, ph);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
